b_reg_wr_sched: RTL

Write-port scheduler for the 32x32 register file. It shares the single register-file write port between two requesters: the pipeline writeback stage (WB) and a long-latency unit (LLU, mult/div), which uses a valid/ready handshake. A scoreboard tracks LLU destinations still pending so decode can stall on RAW/WAW hazards. A bounded-wait policy prevents the LLU from starving by briefly stalling WB.

---
 rtl/b_sched_pkg.sv | 6 +
 rtl/b_scoreboard.sv | 49 ++++
 rtl/b_reg_wr_sched.sv | 82 ++++++++
 3 files changed

// File: rtl/b_sched_pkg.sv
// b_sched_pkg: shared types and constants for the register-file write-port scheduler
package b_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_LLU} gnt_e;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/b_scoreboard.sv
// b_scoreboard: tracks LLU destinations still outstanding and flags decode hazards on them
module b_scoreboard
  import b_sched_pkg::*;
#(
  parameter int MAX_PENDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_i,
  input  logic [4:0]  issue_addr_i,
  output logic        issue_ready_o,
  input  logic        clr_i,
  input  logic [4:0]  clr_addr_i,
  input  logic [4:0]  rs_addr_i,
  input  logic [4:0]  rt_addr_i,
  input  logic [4:0]  dst_addr_i,
  output logic        hazard_o,
  output logic [31:0] pending_o
);
  localparam int CW = $clog2(MAX_PENDING + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_PENDING);
  logic [31:0]   pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          set, clr;
  assign issue_ready_o = rst_n & ~pend_q[issue_addr_i] & (cnt_q < MAXC);
  assign set = issue_i & issue_ready_o & (issue_addr_i != REG_ZERO);
  // only a pending destination is retired; stray transfers leave the count intact
  assign clr = clr_i & pend_q[clr_addr_i];
  always_comb begin
    pend_d = pend_q;
    if (clr) pend_d[clr_addr_i] = 1'b0;
    if (set) pend_d[issue_addr_i] = 1'b1;
    pend_d[0] = 1'b0;
    cnt_d = cnt_q + CW'(set) - CW'(clr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end
  assign hazard_o = rst_n & ((rs_addr_i  != REG_ZERO & pend_q[rs_addr_i]) |
                             (rt_addr_i  != REG_ZERO & pend_q[rt_addr_i]) |
                             (dst_addr_i != REG_ZERO & pend_q[dst_addr_i]));
  assign pending_o = pend_q;
endmodule

// File: rtl/b_reg_wr_sched.sv
// b_reg_wr_sched: shares the register-file write port between WB and the LLU with bounded LLU wait
module b_reg_wr_sched
  import b_sched_pkg::*;
#(
  parameter int MAX_WAIT    = 4,
  parameter int MAX_PENDING = 4,
  parameter int DATA_W      = 32
) (
  input  logic              i_sys_clock,
  input  logic              i_sys_reset,
  input  logic              i_wb_regwr,
  input  logic [4:0]        i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_llu_issue,
  input  logic [4:0]        i_llu_issue_addr,
  output logic              o_llu_issue_ready,
  input  logic              i_llu_valid,
  input  logic [4:0]        i_llu_addr,
  input  logic [DATA_W-1:0] i_llu_data,
  output logic              o_llu_ready,
  input  logic [4:0]        i_id_rs_addr,
  input  logic [4:0]        i_id_rt_addr,
  input  logic [4:0]        i_id_dst_addr,
  output logic              o_hazard,
  output logic              o_stall_wb,
  output logic [4:0]        o_b_reg_wr_addr,
  output logic [DATA_W-1:0] o_b_reg_wr_data,
  output logic              o_b_reg_regwr,
  output logic [31:0]       o_pending
);
  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WLIM = WCW'(MAX_WAIT - 1);
  state_e         state_q, state_d;
  gnt_e           gnt;
  logic [WCW-1:0] cnt_q, cnt_d;
  logic           stall_q, blocked, llu_ready;
  always_comb gnt = (state_q == S_FORCE) ? GNT_LLU :
                    i_wb_regwr           ? GNT_WB  :
                    i_llu_valid          ? GNT_LLU : GNT_NONE;
  assign blocked   = i_llu_valid & (gnt == GNT_WB);
  assign llu_ready = i_sys_reset & (gnt == GNT_LLU);
  // counter holds the number of blocked cycles already seen; the last allowed one forces
  always_comb begin
    state_d = S_IDLE;
    cnt_d   = '0;
    if (state_q != S_FORCE && blocked) begin
      state_d = (cnt_q == WLIM) ? S_FORCE : S_WAIT;
      cnt_d   = (cnt_q == WLIM) ? '0 : cnt_q + 1'b1;
    end
  end
  always_ff @(posedge i_sys_clock or negedge i_sys_reset) begin
    if (!i_sys_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= (state_d == S_FORCE);
    end
  end
  assign o_stall_wb      = stall_q;
  assign o_llu_ready     = llu_ready;
  assign o_b_reg_wr_addr = (gnt == GNT_LLU) ? i_llu_addr : i_wb_addr;
  assign o_b_reg_wr_data = (gnt == GNT_LLU) ? i_llu_data : i_wb_data;
  assign o_b_reg_regwr   = i_sys_reset & (((gnt == GNT_WB) & (i_wb_addr != REG_ZERO)) |
                                          (llu_ready & i_llu_valid & (i_llu_addr != REG_ZERO)));
  b_scoreboard #(.MAX_PENDING(MAX_PENDING)) u_sb (
    .clk          (i_sys_clock),
    .rst_n        (i_sys_reset),
    .issue_i      (i_llu_issue),
    .issue_addr_i (i_llu_issue_addr),
    .issue_ready_o(o_llu_issue_ready),
    .clr_i        (i_llu_valid & llu_ready),
    .clr_addr_i   (i_llu_addr),
    .rs_addr_i    (i_id_rs_addr),
    .rt_addr_i    (i_id_rt_addr),
    .dst_addr_i   (i_id_dst_addr),
    .hazard_o     (o_hazard),
    .pending_o    (o_pending)
  );
endmodule
